// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the 3-bit ALU and its command sequencer.
//   OPW / RESW      : operand and result widths
//   OP_*            : ALU select encodings
//   seq_state_e     : sequencer FSM states
package alu_pkg;

   localparam int unsigned OPW  = 3;
   localparam int unsigned RESW = 4;

   localparam logic [1:0] OP_SUB = 2'd0;
   localparam logic [1:0] OP_ADD = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;
   localparam logic [1:0] OP_AND = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GOT_A = 2'd1,
      EXEC  = 2'd2,
      RESP  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end for the combinational 3-bit ALU.
//   Accepts two-beat commands on in_* (beat 0 = {chain, sel, a}, beat 1 = {3'bx, b}),
//   drives registered alu_a/alu_b/alu_sel, captures alu_result during EXEC and
//   returns it with zero/msb flags on out_* (valid/ready).
//   clk, rst (synchronous, active-high)
//   in_valid/in_ready/in_data[5:0]    command stream
//   alu_a[2:0], alu_b[2:0], alu_sel[1:0], alu_result[3:0]   ALU interface
//   out_valid/out_ready/out_data[3:0], out_zero, out_msb     result stream
// Optional feature macro: ALU_SEQ_CHAIN_EN (beat 0 with chain=1 takes A from the
// low bits of the last delivered result).
import alu_pkg::*;

module alu_op_sequencer (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5:0]      in_data,
   output logic [OPW-1:0]  alu_a,
   output logic [OPW-1:0]  alu_b,
   output logic [1:0]      alu_sel,
   input  logic [RESW-1:0] alu_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [RESW-1:0] out_data,
   output logic            out_zero,
   output logic            out_msb
);

   seq_state_e      state_q, state_d;
   logic [OPW-1:0]  a_q, a_d;
   logic [OPW-1:0]  b_q, b_d;
   logic [1:0]      sel_q, sel_d;
   logic [RESW-1:0] data_q, data_d;
   logic            zero_q, zero_d;
   logic            msb_q, msb_d;
`ifdef ALU_SEQ_CHAIN_EN
   logic [OPW-1:0]  last_q, last_d;
`else
   // beat-1 upper bits and the chain bit carry no meaning in this build
   logic            unused_chain;
   assign unused_chain = in_data[5];
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      data_d  = data_q;
      zero_d  = zero_q;
      msb_d   = msb_q;
`ifdef ALU_SEQ_CHAIN_EN
      last_d  = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d   = in_data[OPW-1:0];
               sel_d = in_data[4:3];
`ifdef ALU_SEQ_CHAIN_EN
               if (in_data[5]) a_d = last_q;
`endif
               state_d = GOT_A;
            end
         end
         GOT_A: begin
            if (in_valid) begin
               b_d     = in_data[OPW-1:0];
               state_d = EXEC;
            end
         end
         EXEC: begin
            data_d  = alu_result;
            zero_d  = (alu_result == '0);
            msb_d   = alu_result[RESW-1];
            state_d = RESP;
         end
         RESP: begin
            if (out_ready) begin
`ifdef ALU_SEQ_CHAIN_EN
               last_d = data_q[OPW-1:0];
`endif
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         zero_q  <= 1'b0;
         msb_q   <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
         last_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         msb_q   <= msb_d;
`ifdef ALU_SEQ_CHAIN_EN
         last_q  <= last_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE) || (state_q == GOT_A);
   assign out_valid = (state_q == RESP);
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_sel   = sel_q;
   assign out_data  = data_q;
   assign out_zero  = zero_q;
   assign out_msb   = msb_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_data;
   logic [2:0] alu_a;
   logic [2:0] alu_b;
   logic [1:0] alu_sel;
   logic [3:0] alu_result;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_zero;
   logic       out_msb;

   int checks   = 0;
   int failures = 0;
   int xfer_cnt = 0;
   int xfer_start;

   always #5 clk = ~clk;

   alu_op_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_result(alu_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zero  (out_zero),
      .out_msb   (out_msb)
   );

   // Stand-in for the external 3-bit ALU.
   always_comb begin
      case (alu_sel)
         2'd0:    alu_result = {1'b0, alu_a} - {1'b0, alu_b};
         2'd1:    alu_result = {1'b0, alu_a} + {1'b0, alu_b};
         2'd2:    alu_result = {1'b0, alu_a ^ alu_b};
         default: alu_result = {1'b0, alu_a & alu_b};
      endcase
   end

   always @(posedge clk)
      if (!rst && out_valid && out_ready) xfer_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [5:0] d, input string tag);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) chk({tag, "_ready_timeout"}, 8'd0, 8'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] sel, input logic [2:0] a, input logic [2:0] b,
                         input logic chain, input logic [2:0] exp_a, input logic [3:0] exp,
                         input string tag);
      send_beat({chain, sel, a}, {tag, "_b0"});
      send_beat({3'b101, b}, {tag, "_b1"});
      chk({tag, "_exec_valid"}, {7'd0, out_valid}, 8'd0);
      chk({tag, "_exec_ready"}, {7'd0, in_ready}, 8'd0);
      chk({tag, "_alu_a"}, {5'd0, alu_a}, {5'd0, exp_a});
      chk({tag, "_alu_b"}, {5'd0, alu_b}, {5'd0, b});
      out_ready = 1'b1;
      tick();
      chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
      chk({tag, "_data"}, {4'd0, out_data}, {4'd0, exp});
      chk({tag, "_zero"}, {7'd0, out_zero}, {7'd0, (exp == 4'd0)});
      chk({tag, "_msb"}, {7'd0, out_msb}, {7'd0, exp[3]});
      tick();
      out_ready = 1'b0;
      chk({tag, "_idle_ready"}, {7'd0, in_ready}, 8'd1);
      chk({tag, "_idle_valid"}, {7'd0, out_valid}, 8'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
      chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
      chk("rst_out_data", {4'd0, out_data}, 8'd0);
      chk("rst_alu_a", {5'd0, alu_a}, 8'd0);
      chk("rst_alu_sel", {6'd0, alu_sel}, 8'd0);

      // Directed operations: SUB 2-5, ADD 7+7, XOR 5^3, AND 6&3, AND 4&3
      run_op(2'd0, 3'd2, 3'd5, 1'b0, 3'd2, 4'hD, "sub_2_5");
      run_op(2'd1, 3'd7, 3'd7, 1'b0, 3'd7, 4'hE, "add_7_7");
      run_op(2'd2, 3'd5, 3'd3, 1'b0, 3'd5, 4'h6, "xor_5_3");
      run_op(2'd3, 3'd6, 3'd3, 1'b0, 3'd6, 4'h2, "and_6_3");
      run_op(2'd3, 3'd4, 3'd3, 1'b0, 3'd4, 4'h0, "and_4_3");

      // Backpressure: ADD 1+2 held in RESP for 3 cycles
      send_beat({1'b0, 2'd1, 3'd1}, "bp_b0");
      send_beat({3'b000, 3'd2}, "bp_b1");
      tick();
      xfer_start = xfer_cnt;
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", {7'd0, out_valid}, 8'd1);
         chk("bp_data", {4'd0, out_data}, 8'h03);
         chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
         chk("bp_alu_a", {5'd0, alu_a}, 8'd1);
         tick();
      end
      out_ready = 1'b1;
      chk("bp_valid_final", {7'd0, out_valid}, 8'd1);
      tick();
      out_ready = 1'b0;
      chk("bp_released", {7'd0, out_valid}, 8'd0);
      chk("bp_single_xfer", 8'(xfer_cnt - xfer_start), 8'd1);

      // Reset in GOT_A discards the partial command
      send_beat({1'b0, 2'd2, 3'd3}, "rst_mid_b0");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_in_ready", {7'd0, in_ready}, 8'd1);
      chk("rstmid_out_valid", {7'd0, out_valid}, 8'd0);
      chk("rstmid_out_data", {4'd0, out_data}, 8'd0);
      chk("rstmid_flags", {6'd0, out_zero, out_msb}, 8'd0);
      chk("rstmid_alu", {alu_sel, alu_a, alu_b}, 8'd0);
      xfer_start = xfer_cnt;
      run_op(2'd2, 3'd7, 3'd1, 1'b0, 3'd7, 4'h6, "xor_7_1");
      chk("rstmid_one_xfer", 8'(xfer_cnt - xfer_start), 8'd1);

      // in_valid held through EXEC/RESP: in_ready pattern 1,1,0,0,1
      in_valid = 1'b1;
      in_data  = {1'b0, 2'd1, 3'd1};
      chk("hold_ir_idle", {7'd0, in_ready}, 8'd1);
      tick();
      chk("hold_ir_gota", {7'd0, in_ready}, 8'd1);
      in_data = {3'b000, 3'd2};
      tick();
      chk("hold_ir_exec", {7'd0, in_ready}, 8'd0);
      in_data = {1'b0, 2'd3, 3'd7};
      tick();
      chk("hold_ir_resp", {7'd0, in_ready}, 8'd0);
      chk("hold_alu_a_kept", {5'd0, alu_a}, 8'd1);
      chk("hold_alu_sel_kept", {6'd0, alu_sel}, 8'd1);
      chk("hold_data", {4'd0, out_data}, 8'h03);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hold_ir_idle2", {7'd0, in_ready}, 8'd1);
      tick();
      in_valid = 1'b0;
      chk("hold_new_a", {5'd0, alu_a}, 8'd7);
      chk("hold_new_sel", {6'd0, alu_sel}, 8'd3);
      send_beat({3'b000, 3'd3}, "hold_b1");
      out_ready = 1'b1;
      tick();
      chk("hold_and_data", {4'd0, out_data}, 8'h03);
      tick();
      out_ready = 1'b0;

`ifdef ALU_SEQ_CHAIN_EN
      run_op(2'd1, 3'd3, 3'd2, 1'b0, 3'd3, 4'h5, "chain_add");
      run_op(2'd0, 3'd7, 3'd1, 1'b1, 3'd5, 4'h4, "chain_sub");
`else
      // chain bit has no effect without the feature
      run_op(2'd1, 3'd1, 3'd1, 1'b1, 3'd1, 4'h2, "nochain_add");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
